// File: rtl/memory_writeback_stage.sv
// memory_writeback_stage
//
// Final stage of the 24-bit processor pipeline. Takes the execute-stage
// outputs, performs the data-memory store or load against a word-addressed
// synchronous RAM, and registers the register-file write port (enable,
// destination, data) that is returned to the decode stage. Every output is
// registered, giving exactly one cycle of latency. One instruction is
// accepted per clock and the stage never stalls.
//
// Optional feature macro: MEM_WB_IO_EN
//   Defined   : word address IO_ADDR is a memory-mapped I/O port. Stores to
//               it drive ioOut, and loads from it return ioIn.
//   Undefined : IO_ADDR is an ordinary address, ioOut is tied to 0 and
//               ioIn is ignored.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   memWe            in   store enable
//   regWe            in   register write enable
//   writeRegFromAlu  in   1 = write back ALU result, 0 = write back load data
//   regToWrite       in   destination register index
//   dataToWrite      in   store data
//   result           in   ALU result, also used as the memory word address
//   ioIn             in   I/O input value (MEM_WB_IO_EN only)
//   regWeOut         out  registered register write enable
//   regToWriteOut    out  registered destination register index
//   wbData           out  registered write-back data
//   memErr           out  sticky out-of-range access flag, cleared by reset
//   ioOut            out  I/O output register (MEM_WB_IO_EN only, else 0)

module memory_writeback_stage #(
  parameter int                DATA_W     = 24,
  parameter int                DEPTH      = 256,
  parameter int                REG_ADDR_W = 4,
  parameter logic [DATA_W-1:0] IO_ADDR    = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memWe,
  input  logic                  regWe,
  input  logic                  writeRegFromAlu,
  input  logic [REG_ADDR_W-1:0] regToWrite,
  input  logic [DATA_W-1:0]     dataToWrite,
  input  logic [DATA_W-1:0]     result,
  input  logic [DATA_W-1:0]     ioIn,
  output logic                  regWeOut,
  output logic [REG_ADDR_W-1:0] regToWriteOut,
  output logic [DATA_W-1:0]     wbData,
  output logic                  memErr,
  output logic [DATA_W-1:0]     ioOut
);

  localparam int                IDX_W       = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] DEPTH_LIMIT = DATA_W'(DEPTH);

  logic [DATA_W-1:0] ram [DEPTH];

  logic              inRange;
  logic [IDX_W-1:0]  ramIndex;
  logic              isLoad;
  logic              ramWrite;
  logic              accessErr;
  logic [DATA_W-1:0] wbDataNext;

  logic              isIo;
  logic [DATA_W-1:0] ioReadData;

`ifdef MEM_WB_IO_EN
  assign isIo       = (result == IO_ADDR);
  assign ioReadData = ioIn;

  // The I/O output register captures store data aimed at IO_ADDR. Stores
  // are ignored while reset is held, just like RAM stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      ioOut <= '0;
    end else if (memWe && isIo) begin
      ioOut <= dataToWrite;
    end
  end
`else
  assign isIo       = 1'b0;
  assign ioReadData = '0;
  assign ioOut      = '0;

  logic unusedIo;
  assign unusedIo = ^{ioIn, IO_ADDR};
`endif

  // Address decode and selection of the next write-back value. The I/O
  // port takes priority over the RAM decode. A load with no backing word
  // returns 0. ALU write-back never consults the RAM or the range check.
  always_comb begin
    inRange    = (result < DEPTH_LIMIT);
    ramIndex   = result[IDX_W-1:0];
    isLoad     = regWe && !writeRegFromAlu;
    ramWrite   = memWe && inRange && !isIo;
    accessErr  = (memWe || isLoad) && !inRange && !isIo;
    wbDataNext = '0;
    if (writeRegFromAlu) begin
      wbDataNext = result;
    end else if (isIo) begin
      wbDataNext = ioReadData;
    end else if (inRange) begin
      wbDataNext = ram[ramIndex];
    end
  end

  // RAM contents survive reset, but no write happens while reset is high.
  // The read in the block above sees the pre-edge contents, so a
  // combined load+store to one address returns the old word.
  always_ff @(posedge clk) begin
    if (!reset && ramWrite) begin
      ram[ramIndex] <= dataToWrite;
    end
  end

  // MEM/WB pipeline register. memErr is sticky until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWeOut      <= 1'b0;
      regToWriteOut <= '0;
      wbData        <= '0;
      memErr        <= 1'b0;
    end else begin
      regWeOut      <= regWe;
      regToWriteOut <= regToWrite;
      wbData        <= wbDataNext;
      memErr        <= memErr | accessErr;
    end
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// tb_memory_writeback_stage
//
// Directed testbench for memory_writeback_stage. It applies a linear
// sequence of hand-written instructions. After each clock edge it compares
// the registered outputs against expected values that were worked out by
// hand. Covered items:
//   - reset values
//   - ALU write-back
//   - store followed by a load
//   - read-before-write swap
//   - range boundaries and the sticky error flag
//   - a store suppressed by reset
//   - the optional I/O port (both builds)

module tb_memory_writeback_stage;

  localparam int DATA_W     = 24;
  localparam int REG_ADDR_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  memWe;
  logic                  regWe;
  logic                  writeRegFromAlu;
  logic [REG_ADDR_W-1:0] regToWrite;
  logic [DATA_W-1:0]     dataToWrite;
  logic [DATA_W-1:0]     result;
  logic [DATA_W-1:0]     ioIn;
  logic                  regWeOut;
  logic [REG_ADDR_W-1:0] regToWriteOut;
  logic [DATA_W-1:0]     wbData;
  logic                  memErr;
  logic [DATA_W-1:0]     ioOut;

  int checks;
  int errors;

  memory_writeback_stage dut (
    .clk             (clk),
    .reset           (reset),
    .memWe           (memWe),
    .regWe           (regWe),
    .writeRegFromAlu (writeRegFromAlu),
    .regToWrite      (regToWrite),
    .dataToWrite     (dataToWrite),
    .result          (result),
    .ioIn            (ioIn),
    .regWeOut        (regWeOut),
    .regToWriteOut   (regToWriteOut),
    .wbData          (wbData),
    .memErr          (memErr),
    .ioOut           (ioOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction, then let one rising edge consume it. Outputs
  // are sampled 1 time unit after that edge.
  task automatic applyStimulus(input logic                  rst,
                               input logic                  mWe,
                               input logic                  rWe,
                               input logic                  fromAlu,
                               input logic [REG_ADDR_W-1:0] dest,
                               input logic [DATA_W-1:0]     storeData,
                               input logic [DATA_W-1:0]     aluResult,
                               input logic [DATA_W-1:0]     ioValue);
    reset           = rst;
    memWe           = mWe;
    regWe           = rWe;
    writeRegFromAlu = fromAlu;
    regToWrite      = dest;
    dataToWrite     = storeData;
    result          = aluResult;
    ioIn            = ioValue;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset edge: every output clears
    applyStimulus(1, 0, 1, 1, 4'd9, 24'h0, 24'h000005, 24'h0);
    checkOutput("rst_regWeOut", 32'(regWeOut), 32'h0);
    checkOutput("rst_regToWriteOut", 32'(regToWriteOut), 32'h0);
    checkOutput("rst_wbData", 32'(wbData), 32'h0);
    checkOutput("rst_memErr", 32'(memErr), 32'h0);
    checkOutput("rst_ioOut", 32'(ioOut), 32'h0);

    // Idle cycle
    applyStimulus(0, 0, 0, 1, 4'd0, 24'h0, 24'h0, 24'h0);
    checkOutput("idle_regWeOut", 32'(regWeOut), 32'h0);
    checkOutput("idle_wbData", 32'(wbData), 32'h0);
    checkOutput("idle_memErr", 32'(memErr), 32'h0);

    // ALU write-back
    applyStimulus(0, 0, 1, 1, 4'd2, 24'h0, 24'h000001, 24'h0);
    checkOutput("alu_regWeOut", 32'(regWeOut), 32'h1);
    checkOutput("alu_regToWriteOut", 32'(regToWriteOut), 32'h2);
    checkOutput("alu_wbData", 32'(wbData), 32'h1);
    checkOutput("alu_memErr", 32'(memErr), 32'h0);

    // ALU result far out of RAM range is not a memory access
    applyStimulus(0, 0, 1, 1, 4'd3, 24'h0, 24'h000400, 24'h0);
    checkOutput("aluFar_wbData", 32'(wbData), 32'h400);
    checkOutput("aluFar_memErr", 32'(memErr), 32'h0);

    // Store 00ABCD at address 3, then load it back
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h00ABCD, 24'h000003, 24'h0);
    checkOutput("store_regWeOut", 32'(regWeOut), 32'h0);
    applyStimulus(0, 0, 1, 0, 4'd7, 24'h0, 24'h000003, 24'h0);
    checkOutput("load3_wbData", 32'(wbData), 32'h00ABCD);
    checkOutput("load3_regToWriteOut", 32'(regToWriteOut), 32'h7);
    checkOutput("load3_regWeOut", 32'(regWeOut), 32'h1);
    checkOutput("load3_memErr", 32'(memErr), 32'h0);

    // Swap at address 5: the first load sees the old word
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h000011, 24'h000005, 24'h0);
    applyStimulus(0, 1, 1, 0, 4'd4, 24'h000022, 24'h000005, 24'h0);
    checkOutput("swap_wbData_old", 32'(wbData), 32'h000011);
    checkOutput("swap_regToWriteOut", 32'(regToWriteOut), 32'h4);
    applyStimulus(0, 0, 1, 0, 4'd4, 24'h0, 24'h000005, 24'h0);
    checkOutput("swap_wbData_new", 32'(wbData), 32'h000022);

    // Top in-range word (255) and address 0
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h0000FF, 24'h0000FF, 24'h0);
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h000777, 24'h000000, 24'h0);
    applyStimulus(0, 0, 1, 0, 4'd1, 24'h0, 24'h0000FF, 24'h0);
    checkOutput("load255_wbData", 32'(wbData), 32'h0000FF);
    checkOutput("load255_memErr", 32'(memErr), 32'h0);

    // Store to 256 (first out-of-range word): flagged and no aliasing onto 0
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h000999, 24'h000100, 24'h0);
    checkOutput("store256_memErr", 32'(memErr), 32'h1);
    applyStimulus(0, 0, 1, 0, 4'd6, 24'h0, 24'h000000, 24'h0);
    checkOutput("load0_noAlias", 32'(wbData), 32'h000777);

    // Reset clears memErr
    applyStimulus(1, 0, 0, 1, 4'd0, 24'h0, 24'h0, 24'h0);
    checkOutput("rst2_memErr", 32'(memErr), 32'h0);

    // Load from 300: returns 0 and sets memErr, which then stays sticky
    applyStimulus(0, 0, 1, 0, 4'd8, 24'h0, 24'd300, 24'h0);
    checkOutput("load300_wbData", 32'(wbData), 32'h0);
    checkOutput("load300_memErr", 32'(memErr), 32'h1);
    checkOutput("load300_regWeOut", 32'(regWeOut), 32'h1);
    checkOutput("load300_regToWriteOut", 32'(regToWriteOut), 32'h8);
    applyStimulus(0, 0, 1, 1, 4'd5, 24'h0, 24'h000042, 24'h0);
    checkOutput("sticky_wbData", 32'(wbData), 32'h42);
    checkOutput("sticky_memErr", 32'(memErr), 32'h1);

    // Reset mid-stream: the in-flight instruction and its store are dropped
    applyStimulus(1, 1, 1, 1, 4'd3, 24'h000555, 24'h000003, 24'h0);
    checkOutput("rstMid_regWeOut", 32'(regWeOut), 32'h0);
    checkOutput("rstMid_regToWriteOut", 32'(regToWriteOut), 32'h0);
    checkOutput("rstMid_wbData", 32'(wbData), 32'h0);
    checkOutput("rstMid_memErr", 32'(memErr), 32'h0);
    applyStimulus(0, 0, 1, 0, 4'd7, 24'h0, 24'h000003, 24'h0);
    checkOutput("rstMid_ramKept", 32'(wbData), 32'h00ABCD);

`ifdef MEM_WB_IO_EN
    // I/O port: store drives ioOut, load returns ioIn, no error in either case
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h123456, 24'hFFFFFF, 24'h0);
    checkOutput("ioStore_ioOut", 32'(ioOut), 32'h123456);
    checkOutput("ioStore_memErr", 32'(memErr), 32'h0);
    applyStimulus(0, 0, 1, 0, 4'd2, 24'h0, 24'hFFFFFF, 24'h00BEEF);
    checkOutput("ioLoad_wbData", 32'(wbData), 32'h00BEEF);
    checkOutput("ioLoad_memErr", 32'(memErr), 32'h0);
`else
    // Without the I/O port, IO_ADDR is just an out-of-range address
    applyStimulus(0, 1, 0, 1, 4'd0, 24'h123456, 24'hFFFFFF, 24'h0);
    checkOutput("ioStore_ioOut", 32'(ioOut), 32'h0);
    checkOutput("ioStore_memErr", 32'(memErr), 32'h1);
    applyStimulus(0, 0, 1, 0, 4'd2, 24'h0, 24'hFFFFFF, 24'h00BEEF);
    checkOutput("ioLoad_wbData", 32'(wbData), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_writeback_stage.md
Name: memory_writeback_stage

Overview:
- Final pipeline stage of the 24-bit processor: consumes execution-stage outputs, performs data-memory store/load, returns the register-file write port signals (write enable, data, destination) to the decode stage.
- Contains word-addressed synchronous data RAM and the MEM/WB pipeline register.
- All outputs registered.
- One instruction accepted per clock; no stalls.

Parameters:
- DATA_W, 24, datapath width.
- DEPTH, 256, data RAM words; power of two, >= 2.
- REG_ADDR_W, 4, register index width.
- IO_ADDR, 24'hFFFFFF, memory-mapped I/O word address (only with MEM_WB_IO_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- memWe  in  1  store enable from execute.
- regWe  in  1  register write enable from execute.
- writeRegFromAlu  in  1  1 = write back ALU result; 0 = write back memory read data.
- regToWrite  in  REG_ADDR_W  destination register from execute.
- dataToWrite  in  DATA_W  store data.
- result  in  DATA_W  ALU result; also memory address.
- regWeOut  out  1  register-file write enable to decode.
- regToWriteOut  out  REG_ADDR_W  destination to decode.
- wbData  out  DATA_W  write-back data to decode.
- memErr  out  1  sticky out-of-range access flag.
- ioOut  out  DATA_W  I/O output register (0 when MEM_WB_IO_EN undefined).
- ioIn  in  DATA_W  I/O input value (ignored when MEM_WB_IO_EN undefined).

Behaviour:
- Reset, sampled at rising edge: regWeOut=0, regToWriteOut=0, wbData=0, memErr=0, ioOut=0. RAM contents retained. Stores suppressed while reset=1.
- Latency: inputs sampled at edge N; regWeOut/regToWriteOut/wbData valid after edge N until edge N+1. Exactly one-cycle latency.
- Address: addr = result. In range iff result < DEPTH; index = result[log2(DEPTH)-1:0].
- Store, memWe=1: in range -> RAM[index] <= dataToWrite at edge N. Out of range (and not I/O) -> no write; memErr <= 1.
- Load, regWe=1 and writeRegFromAlu=0: wbData <= RAM[index] at edge N (synchronous read). Out of range -> wbData <= 0; memErr <= 1.
- ALU write-back, writeRegFromAlu=1: wbData <= result. RAM never read or flagged, regardless of address.
- regWeOut <= regWe. regToWriteOut <= regToWrite. Both pass through unchanged, including when memErr is set.
- regWe=0 and memWe=0: regWeOut <= 0. wbData still updates per the writeRegFromAlu rule; don't-care to downstream.
- Same instruction with memWe=1, regWe=1, writeRegFromAlu=0 (swap): read-before-write. wbData gets the old RAM word; the new word is visible from edge N+1.
- Back-to-back store then load, same address: the load at edge N+1 returns data stored at edge N.
- memErr is sticky; cleared only by reset.
- Reset asserted mid-stream: the in-flight instruction is discarded; outputs are 0 after the reset edge.

Optional Feature:
- Macro: MEM_WB_IO_EN.
- Defined:
  - Store to result==IO_ADDR -> ioOut <= dataToWrite; no RAM write; no memErr.
  - Load from IO_ADDR -> wbData <= ioIn, sampled at edge N; no memErr.
  - ioOut reset value 0.
- Undefined:
  - IO_ADDR is an ordinary address: out of range for DEPTH=256, so memErr is set.
  - ioOut tied to 0; ioIn unused.

Test Plan:
- Reset 1 cycle, then idle -> regWeOut=0, regToWriteOut=0, wbData=0, memErr=0.
- regWe=1, writeRegFromAlu=1, regToWrite=2, result=1 -> next cycle: regWeOut=1, regToWriteOut=2, wbData=1, memErr=0.
- Store memWe=1, result=3, dataToWrite=24'h00ABCD; next cycle load regWe=1, writeRegFromAlu=0, regToWrite=7, result=3 -> after the load edge: wbData=24'h00ABCD, regToWriteOut=7, regWeOut=1.
- Swap at address 5 (RAM[5]=24'h000011, dataToWrite=24'h000022) -> wbData=24'h000011; a following load of 5 -> wbData=24'h000022.
- Load result=300 (DEPTH=256) -> wbData=0, memErr=1; memErr stays 1 through later valid ops; reset clears it.
- MEM_WB_IO_EN defined: store 24'h123456 to 24'hFFFFFF -> ioOut=24'h123456, memErr=0; load from 24'hFFFFFF with ioIn=24'h00BEEF -> wbData=24'h00BEEF.
